// File: rtl/phase_loop_pkg.sv
// Shared definitions for the phase-modulation loop: state encoding,
// default accumulator width and 32-bit saturation.
package phase_loop_pkg;

  localparam int ACC_WIDTH_DEF = 48;
  localparam int SAT_IN_W      = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Caller sign-extends its wide result to SAT_IN_W before clamping.
  function automatic logic signed [31:0] sat32(input logic signed [SAT_IN_W-1:0] v);
    if (v > 128'sd2147483647)
      return 32'sh7fffffff;
    else if (v < -128'sd2147483648)
      return 32'sh80000000;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/demod_err_pipe.sv
// Error pipeline: captures the half-period sums, forms sum_H - sum_L - offset,
// saturates to 32 bits and issues the delayed ramp-accumulate strobe.
module demod_err_pipe
  import phase_loop_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cap,
  input  logic signed [ACC_WIDTH-1:0] i_sum_h,
  input  logic signed [ACC_WIDTH-1:0] i_sum_l,
  input  logic signed [31:0]          i_offset,
  output logic signed [31:0]          o_step,
  output logic                        o_step_valid,
  output logic                        o_trig
);

  localparam int DIFF_W = ACC_WIDTH + 2;

  logic signed [ACC_WIDTH-1:0] r_sum_h_p0;
  logic signed [ACC_WIDTH-1:0] r_sum_l_p0;
  logic signed [31:0]          r_off_p0;
  logic                        r_vld_p0;
  logic signed [31:0]          r_step_p1;
  logic                        r_vld_p1;
  logic                        r_trig_p2;
  logic signed [DIFF_W-1:0]    w_diff_p0;

  assign w_diff_p0 = DIFF_W'(r_sum_h_p0) - DIFF_W'(r_sum_l_p0) - DIFF_W'(r_off_p0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum_h_p0 <= '0;
      r_sum_l_p0 <= '0;
      r_off_p0   <= '0;
      r_vld_p0   <= 1'b0;
      r_step_p1  <= '0;
      r_vld_p1   <= 1'b0;
      r_trig_p2  <= 1'b0;
    end else begin
      // p0: capture the completed period's sums and its offset
      r_vld_p0 <= i_cap;
      if (i_cap) begin
        r_sum_h_p0 <= i_sum_h;
        r_sum_l_p0 <= i_sum_l;
        r_off_p0   <= i_offset;
      end
      // p1: subtract and saturate; the step holds between updates
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0)
        r_step_p1 <= sat32(SAT_IN_W'(w_diff_p0));
      // p2: ramp strobe follows the step by one clock
      r_trig_p2 <= r_vld_p1;
    end
  end

  assign o_step       = r_step_p1;
  assign o_step_valid = r_vld_p1;
  assign o_trig       = r_trig_p2;

endmodule

// File: rtl/phase_demod_step_gen.sv
// Square-wave phase modulator with synchronous demodulation: alternates
// amp_H/amp_L every F clocks and turns each full period into a ramp step.
module phase_demod_step_gen
  import phase_loop_pkg::*;
#(
  parameter int ADC_WIDTH = 14,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic signed [ADC_WIDTH-1:0] i_adc_data,
  input  logic                        i_adc_valid,
  input  logic [31:0]                 i_freq,
  input  logic [31:0]                 i_wait_cnt,
  input  logic signed [31:0]          i_amp_H,
  input  logic signed [31:0]          i_amp_L,
  input  logic signed [31:0]          i_err_offset,
  output logic signed [31:0]          o_mod,
  output logic                        o_mod_trig,
  output logic signed [31:0]          o_step,
  output logic                        o_step_valid,
  output logic [1:0]                  o_state
);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_armed;
  logic [31:0]                 r_cnt;
  logic [31:0]                 r_f;
  logic [31:0]                 r_w;
  logic signed [31:0]          r_amp_h;
  logic signed [31:0]          r_amp_l;
  logic signed [31:0]          r_off;
  logic signed [31:0]          r_mod;
  logic signed [ACC_WIDTH-1:0] r_sum_h;
  logic signed [ACC_WIDTH-1:0] r_sum_l;

  logic                        w_last;
  logic                        w_take;
  logic                        w_enter_high;
  logic                        w_enter_low;
  logic                        w_cap;
  logic [31:0]                 w_f_new;
  logic signed [ACC_WIDTH-1:0] w_sample;
  logic signed [ACC_WIDTH-1:0] w_sum_h_nxt;
  logic signed [ACC_WIDTH-1:0] w_sum_l_nxt;

  assign w_f_new  = (i_freq < 32'd2) ? 32'd2 : i_freq;
  assign w_last   = (r_cnt == (r_f - 32'd1));
  assign w_take   = i_adc_valid && (r_cnt >= r_w);
  assign w_sample = ACC_WIDTH'(i_adc_data);

  // The sample on a half's final clock still lands in that half's sum.
  assign w_sum_h_nxt = (r_state == ST_HIGH && w_take) ? r_sum_h + w_sample : r_sum_h;
  assign w_sum_l_nxt = (r_state == ST_LOW  && w_take) ? r_sum_l + w_sample : r_sum_l;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_en && r_armed) w_state_nxt = ST_HIGH;
      ST_HIGH: if (w_last)          w_state_nxt = ST_LOW;
      ST_LOW:  if (w_last)          w_state_nxt = ST_HIGH;
      default:                      w_state_nxt = ST_IDLE;
    endcase
    if (!i_en)
      w_state_nxt = ST_IDLE;
  end

  assign w_enter_high = (w_state_nxt == ST_HIGH) && (r_state != ST_HIGH);
  assign w_enter_low  = (w_state_nxt == ST_LOW)  && (r_state != ST_LOW);
  assign w_cap        = (r_state == ST_LOW) && w_last;

  // r_armed keeps the first HIGH entry at least two clocks after reset release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_w     <= '0;
      r_amp_h <= '0;
      r_amp_l <= '0;
      r_off   <= '0;
      r_mod   <= '0;
      r_sum_h <= '0;
      r_sum_l <= '0;
    end else begin
      r_armed <= 1'b1;
      r_state <= w_state_nxt;
      if (w_enter_high) begin
        r_f     <= w_f_new;
        r_w     <= i_wait_cnt;
        r_amp_h <= i_amp_H;
        r_amp_l <= i_amp_L;
        r_off   <= i_err_offset;
      end
      if (w_enter_high || w_enter_low || w_state_nxt == ST_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 32'd1;
      if (w_enter_high || w_state_nxt == ST_IDLE) begin
        r_sum_h <= '0;
        r_sum_l <= '0;
      end else begin
        r_sum_h <= w_sum_h_nxt;
        r_sum_l <= w_sum_l_nxt;
      end
      case (w_state_nxt)
        ST_HIGH: r_mod <= w_enter_high ? i_amp_H : r_amp_h;
        ST_LOW:  r_mod <= r_amp_l;
        default: r_mod <= '0;
      endcase
    end
  end

  demod_err_pipe #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_err_pipe (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cap        (w_cap),
    .i_sum_h      (w_sum_h_nxt),
    .i_sum_l      (w_sum_l_nxt),
    .i_offset     (r_off),
    .o_step       (o_step),
    .o_step_valid (o_step_valid),
    .o_trig       (o_mod_trig)
  );

  assign o_mod   = r_mod;
  assign o_state = r_state;

endmodule

// File: tb/tb_phase_demod_step_gen.sv
// Self-checking bench for phase_demod_step_gen: vector table driven against a
// timeline model, with a step scoreboard and hand-written abort/reset sequences.
module tb_phase_demod_step_gen;

  logic               clk;
  logic               i_rst;
  logic               i_en;
  logic signed [13:0] i_adc_data;
  logic               i_adc_valid;
  logic [31:0]        i_freq;
  logic [31:0]        i_wait_cnt;
  logic signed [31:0] i_amp_H;
  logic signed [31:0] i_amp_L;
  logic signed [31:0] i_err_offset;
  logic signed [31:0] o_mod;
  logic               o_mod_trig;
  logic signed [31:0] o_step;
  logic               o_step_valid;
  logic [1:0]         o_state;

  phase_demod_step_gen dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_adc_data   (i_adc_data),
    .i_adc_valid  (i_adc_valid),
    .i_freq       (i_freq),
    .i_wait_cnt   (i_wait_cnt),
    .i_amp_H      (i_amp_H),
    .i_amp_L      (i_amp_L),
    .i_err_offset (i_err_offset),
    .o_mod        (o_mod),
    .o_mod_trig   (o_mod_trig),
    .o_step       (o_step),
    .o_step_valid (o_step_valid),
    .o_state      (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        freq;
    logic [31:0]        wait_c;
    int                 adc_h;
    int                 adc_l;
    logic signed [31:0] off;
    logic signed [31:0] exp_step;
    bit                 gap;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  int n_chk  = 0;
  int n_pass = 0;
  logic signed [31:0] exp_q [$];
  logic signed [31:0] g_hold = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard: every step pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!i_rst && o_step_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_step_valid: got step %0d, expected no pulse", o_step);
      end else begin
        check("scoreboard_step", o_step, exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, o_state, 0);
    check({tag, "_mod"}, o_mod, 0);
    check({tag, "_trig"}, o_mod_trig, 0);
    check({tag, "_step"}, o_step, 0);
    check({tag, "_step_valid"}, o_step_valid, 0);
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    i_en = 1'b0;
    i_adc_valid = 1'b0;
    i_adc_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    exp_q.delete();
    g_hold = 0;
    i_rst = 1'b0;
  endtask

  // abort_t < 0 means run two full periods; rst_t >= 0 asserts reset at that cycle.
  task automatic run_vec(input int vi, input int abort_in, input int rst_t, input bit with_reset);
    vec_t v;
    int f, per, kmax, abort_t, ph, es;
    logic signed [31:0] em, hold, amp_h, amp_l;
    bit ev, et;
    v = tbl[vi];
    f = (v.freq < 2) ? 2 : int'(v.freq);
    per = 2 * f;
    abort_t = (abort_in < 0) ? 2 * per : abort_in;
    kmax = abort_t / per;
    amp_h = 1000 + vi;
    amp_l = -2000 - vi;
    if (with_reset) apply_reset();
    hold = g_hold;
    i_freq = v.freq;
    i_wait_cnt = v.wait_c;
    i_amp_H = amp_h;
    i_amp_L = amp_l;
    i_err_offset = v.off;
    i_adc_data = '0;
    i_adc_valid = 1'b0;
    i_en = 1'b1;
    if (with_reset) begin
      @(posedge clk);
      @(negedge clk);
      check("first_clk_after_reset_idle", o_state, 0);
    end
    for (int t = 0; t <= abort_t + 4; t++) begin
      @(posedge clk);
      @(negedge clk);
      ph = t % per;
      es = (t > abort_t) ? 0 : ((ph < f) ? 1 : 2);
      em = (es == 1) ? amp_h : ((es == 2) ? amp_l : 32'sd0);
      ev = (t > per) && ((t - 1) % per == 0) && ((t - 1) / per <= kmax);
      et = (t > per + 1) && ((t - 2) % per == 0) && ((t - 2) / per <= kmax);
      if (ev) hold = v.exp_step;
      check($sformatf("v%0d_t%0d_state", vi, t), o_state, es);
      check($sformatf("v%0d_t%0d_mod", vi, t), o_mod, em);
      check($sformatf("v%0d_t%0d_step_valid", vi, t), o_step_valid, ev);
      check($sformatf("v%0d_t%0d_mod_trig", vi, t), o_mod_trig, et);
      check($sformatf("v%0d_t%0d_step_hold", vi, t), o_step, hold);
      if (t <= abort_t && ph == 0 && (t / per) < kmax) exp_q.push_back(v.exp_step);
      i_adc_data = 14'((ph < f) ? v.adc_h : v.adc_l);
      i_adc_valid = v.gap ? (t % 2 == 0) : 1'b1;
      if (t == rst_t) begin
        i_rst = 1'b1;
        #1;
        check_all_zero("async_reset_mid_low");
        exp_q.delete();
        hold = 0;
        break;
      end
      if (t == abort_t) i_en = 1'b0;
    end
    check($sformatf("v%0d_queue_drained", vi), exp_q.size(), 0);
    g_hold = hold;
  endtask

  task automatic freq_change_seq();
    int es;
    apply_reset();
    i_freq = 32'd4;
    i_wait_cnt = 32'd1;
    i_amp_H = 32'sd77;
    i_amp_L = -32'sd77;
    i_err_offset = 32'sd0;
    i_adc_data = 14'sd100;
    i_adc_valid = 1'b1;
    i_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int t = 0; t <= 15; t++) begin
      @(posedge clk);
      @(negedge clk);
      es = (t < 4) ? 1 : (t < 8) ? 2 : (t < 14) ? 1 : 2;
      check($sformatf("fchg_t%0d_state", t), o_state, es);
      if (t == 0) exp_q.push_back(32'sd0);
      if (t == 1) i_freq = 32'd6;
      if (t == 15) i_en = 1'b0;
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("fchg_idle_after_disable", o_state, 0);
    end
    check("fchg_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{32'd4, 32'd1,   100,   100, 32'sd0,          32'sd0,          1'b0};
    tbl[1] = '{32'd4, 32'd1,   100,  -100, 32'sd0,          32'sd600,        1'b0};
    tbl[2] = '{32'd4, 32'd5,    50,    20, -32'sd7,         32'sd7,          1'b0};
    tbl[3] = '{32'd4, 32'd0,  8191,  8191, 32'sh80000000,   32'sh7fffffff,   1'b0};
    tbl[4] = '{32'd1, 32'd0,    10,    -3, 32'sd5,          32'sd21,         1'b0};
    tbl[5] = '{32'd6, 32'd0, -8192,  8191, 32'sh7fffffff,   32'sh80000000,   1'b0};
    tbl[6] = '{32'd5, 32'd4, -1000,   250, 32'sd100,        -32'sd1350,      1'b0};
    tbl[7] = '{32'd0, 32'd1,     7,     3, 32'sd0,          32'sd4,          1'b0};
    tbl[8] = '{32'd4, 32'd0,    40,   -10, 32'sd0,          32'sd100,        1'b1};
    tbl[9] = '{32'd4, 32'd1,    20,    10, 32'sd0,          32'sd30,         1'b0};

    i_rst = 1'b1;
    i_en = 1'b0;
    i_adc_data = '0;
    i_adc_valid = 1'b0;
    i_freq = '0;
    i_wait_cnt = '0;
    i_amp_H = '0;
    i_amp_L = '0;
    i_err_offset = '0;

    for (int vi = 0; vi < NV; vi++) run_vec(vi, -1, -1, 1'b1);

    // Disable at HIGH counter 2 of the second period, then re-enable without reset.
    run_vec(1, 10, -1, 1'b1);
    run_vec(9, -1, -1, 1'b0);

    // Reset asserted in the LOW half after a step of 600 is already visible.
    run_vec(1, 13, 13, 1'b1);

    freq_change_seq();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
